// File: rtl/serial_subtractor_using_fs.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first.
// One full-subtractor cell plus a borrow flop carried between bits.
module serial_subtractor_using_fs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor cell on the current LSBs; res_sr keeps only
  // the bits that survive into the final result.
  always_comb begin
    a0      = a_sr[0];
    b0      = b_sr[0];
    d       = a0 ^ b0 ^ br;
    br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nxt = {d, res_sr};
  end

  // Control FSM, operand/result shifters and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_nxt;
          res_sr <= res_nxt[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= res_nxt;
            bout  <= br_nxt;
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_using_fs.sv
// Directed bench for the bit-serial subtractor.
// Covers WIDTH=8 timing/arith and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor_using_fs;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       bin2;
  logic       busy2;
  logic       done2;
  logic [1:0] diff2;
  logic       bout2;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_subtractor_using_fs #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done),
    .diff(diff), .bout(bout)
  );

  serial_subtractor_using_fs #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2),
    .diff(diff2), .bout(bout2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       input logic c,
                       input logic scr,
                       input logic [7:0] ed,
                       input logic eb);
    int nb;
    logic got;
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) nb++;
      if (scr && i == 2) begin
        a = 8'hAA;
        b = 8'h55;
      end
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cyc"}, 32'(nb), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int t0;
    int t1;
    int t2;
    int both;
    int dbl;
    logic pd;
    logic got;
    logic [2:0] exp3;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    do_op("c1", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0);
    do_op("c2a", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
    do_op("c2b", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_op("c2c", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0);
    do_op("c2d", 8'hC3, 8'h41, 1'b1, 1'b0, 8'h81, 1'b0);

    // start held high: one acceptance every WIDTH+2 cycles
    a = 8'h5A; b = 8'h3C; bin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ndone = 0; t0 = 0; t1 = 0; t2 = 0;
    both = 0; dbl = 0; pd = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (busy && done) both++;
      if (done && pd) dbl++;
      if (done) begin
        if (ndone == 0) t0 = i;
        if (ndone == 1) t1 = i;
        if (ndone == 2) t2 = i;
        ndone++;
        chk("c3_diff", 32'(diff), 32'h1E);
      end
      pd = done;
    end
    start = 1'b0;
    chk("c3_ndone", 32'(ndone), 32'd3);
    chk("c3_gap1", 32'(t1 - t0), 32'd10);
    chk("c3_gap2", 32'(t2 - t1), 32'd10);
    chk("c3_both", 32'(both), 32'd0);
    chk("c3_dbl", 32'(dbl), 32'd0);
    repeat (12) @(negedge clk);

    do_op("c4", 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);

    // reset on the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c5_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("c5_busy", 32'(busy), 32'd0);
    chk("c5_done", 32'(done), 32'd0);
    chk("c5_diff", 32'(diff), 32'd0);
    chk("c5_bout", 32'(bout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("c5_no_done", 32'(ndone), 32'd0);
    do_op("c5_fresh", 8'h10, 8'h20, 1'b1, 1'b0, 8'hEF, 1'b1);

    // WIDTH=2 exhaustive sweep
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      a2 = 2'(k >> 3);
      b2 = 2'(k >> 1);
      bin2 = k[0];
      exp3 = 3'({1'b0, a2} - {1'b0, b2} - {2'b00, bin2});
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (done2) got = 1'b1;
        else @(negedge clk);
      end
      chk($sformatf("w2_%0d_%0d_%0d", a2, b2, bin2),
          32'({got, bout2, diff2}), 32'({1'b1, exp3}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
